// File: rtl/pwm_core8_if.sv
// Bus between the PWM register block (master) and the eight-channel PWM core (slave).
// Carries the E/T/D register fields, the restart strobe and the per-channel status.
interface pwm_core8_if #(
  parameter int NCH = 8,
  parameter int W   = 32
);
  logic [NCH-1:0]   en;
  logic [NCH*W-1:0] period;
  logic [NCH*W-1:0] duty;
  logic             restart;
  logic [NCH-1:0]   pwm;
  logic [NCH-1:0]   active;
  logic [NCH-1:0]   cyc_done;

  modport master (
    output en, period, duty, restart,
    input  pwm, active, cyc_done
  );

  modport slave (
    input  en, period, duty, restart,
    output pwm, active, cyc_done
  );
endinterface

// File: rtl/pwm_core8.sv
// Eight-channel PWM generator with period/duty shadow registers that only reload at a
// period boundary or a global restart, so bus writes never glitch a running cycle.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  S_IDLE | channel off; pwm=0, waiting for en with a non-zero period
//  S_RUN  | counting 0..per_sh-1; pwm high while cnt < duty_sh
module pwm_core8 #(
  parameter int NCH = 8,
  parameter int W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pwm_core8_if.slave  bus
);

  localparam logic [0:0]   S_IDLE = 1'b0;
  localparam logic [0:0]   S_RUN  = 1'b1;
  localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [0:0]   state;
    logic [W-1:0] cnt;
    logic [W-1:0] per_sh;
    logic [W-1:0] duty_sh;
    logic         pwm_r;
    logic         act_r;
    logic         done_r;
    logic [W-1:0] per_in;
    logic [W-1:0] duty_in;
    logic         per_zero;
    logic         wrap;

    assign per_in   = bus.period[i*W +: W];
    assign duty_in  = bus.duty[i*W +: W];
    assign per_zero = (per_in == '0);
    // per_sh is never zero in RUN, so the subtraction cannot underflow there
    assign wrap     = (cnt == per_sh - ONE);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= S_IDLE;
        cnt     <= '0;
        per_sh  <= '0;
        duty_sh <= '0;
        pwm_r   <= 1'b0;
        act_r   <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            pwm_r  <= 1'b0;
            done_r <= 1'b0;
            act_r  <= 1'b0;
            cnt    <= '0;
            if (bus.en[i] && !per_zero) begin
              per_sh  <= per_in;
              duty_sh <= duty_in;
              act_r   <= 1'b1;
              state   <= S_RUN;
            end
          end
          S_RUN: begin
            pwm_r <= (cnt < duty_sh);
            if (bus.restart) begin
              // restart takes priority over a coinciding wrap: no completion pulse
              cnt     <= '0;
              per_sh  <= per_in;
              duty_sh <= duty_in;
              done_r  <= 1'b0;
              if (per_zero) begin
                state <= S_IDLE;
                act_r <= 1'b0;
              end
            end else if (wrap) begin
              cnt     <= '0;
              per_sh  <= per_in;
              duty_sh <= duty_in;
              done_r  <= 1'b1;
              if (!bus.en[i] || per_zero) begin
                state <= S_IDLE;
                act_r <= 1'b0;
              end
            end else begin
              cnt    <= cnt + ONE;
              done_r <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            act_r <= 1'b0;
            pwm_r <= 1'b0;
          end
        endcase
      end
    end

    assign bus.pwm[i]      = pwm_r;
    assign bus.active[i]   = act_r;
    assign bus.cyc_done[i] = done_r;
  end

endmodule

// File: tb/tb_pwm_core8.sv
// Self-checking bench for pwm_core8: vector table, directed corner sequences and a
// randomized run compared against a cycle-level behavioural model.
module tb_pwm_core8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  pwm_core8_if #(.NCH(8), .W(32)) bus ();

  pwm_core8 #(.NCH(8), .W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [7:0]  en;
    logic [31:0] per;
    logic [31:0] dt;
    logic [7:0]  exp_pwm;
    logic [7:0]  exp_act;
    logic [7:0]  exp_cd;
  } vec_t;

  vec_t vecs[28];

  // behavioural model: position within the current period plus latched period/duty
  bit          m_run[8];
  int unsigned m_pos[8];
  int unsigned m_per[8];
  int unsigned m_dt[8];
  logic [7:0]  m_pwm, m_act, m_cd;

  task automatic model_step();
    for (int c = 0; c < 8; c++) begin
      int unsigned p_in, d_in;
      p_in = bus.period[c*32 +: 32];
      d_in = bus.duty[c*32 +: 32];
      if (!rst_n) begin
        m_run[c] = 0; m_pos[c] = 0; m_per[c] = 0; m_dt[c] = 0;
        m_pwm[c] = 0; m_act[c] = 0; m_cd[c] = 0;
      end else if (!m_run[c]) begin
        m_pwm[c] = 0; m_cd[c] = 0; m_act[c] = 0;
        if (bus.en[c] && p_in != 0) begin
          m_run[c] = 1; m_pos[c] = 0; m_per[c] = p_in; m_dt[c] = d_in; m_act[c] = 1;
        end
      end else begin
        m_pwm[c] = (m_pos[c] < m_dt[c]);
        if (bus.restart || m_pos[c] + 1 == m_per[c]) begin
          m_cd[c]  = !bus.restart;
          m_pos[c] = 0; m_per[c] = p_in; m_dt[c] = d_in;
          if (p_in == 0 || (!bus.restart && !bus.en[c])) begin
            m_run[c] = 0; m_act[c] = 0;
          end
        end else begin
          m_pos[c] = m_pos[c] + 1;
          m_cd[c]  = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int c, input int unsigned p, input int unsigned d);
    bus.period[c*32 +: 32] = p;
    bus.duty[c*32 +: 32]   = d;
  endtask

  task automatic do_reset();
    bus.en = '0; bus.restart = 1'b0; bus.period = '0; bus.duty = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int h1, h2, ncd;
    bit bad1, bad2, bad3, misalign;

    rst_n = 1'b0;
    bus.en = '0; bus.restart = 1'b0; bus.period = '0; bus.duty = '0;

    // reset hold rows, then ch0 enabled with period 10 / duty 3
    for (int k = 0; k < 28; k++) begin
      vecs[k].per = 10; vecs[k].dt = 3; vecs[k].exp_act = '0;
      vecs[k].exp_pwm = '0; vecs[k].exp_cd = '0;
      if (k < 3) begin
        vecs[k].rst_n = 1'b0; vecs[k].en = 8'hFF;
      end else begin
        int e;
        e = k - 3;
        vecs[k].rst_n      = 1'b1;
        vecs[k].en         = 8'h01;
        vecs[k].exp_act[0] = 1'b1;
        vecs[k].exp_pwm[0] = (e >= 1) && (((e - 1) % 10) < 3);
        vecs[k].exp_cd[0]  = (e >= 10) && ((e % 10) == 0);
      end
    end

    for (int k = 0; k < 28; k++) begin
      rst_n  = vecs[k].rst_n;
      bus.en = vecs[k].en;
      for (int c = 0; c < 8; c++) set_ch(c, vecs[k].per, vecs[k].dt);
      tick();
      check($sformatf("vec%0d pwm", k), {24'd0, bus.pwm}, {24'd0, vecs[k].exp_pwm});
      check($sformatf("vec%0d active", k), {24'd0, bus.active}, {24'd0, vecs[k].exp_act});
      check($sformatf("vec%0d cyc_done", k), {24'd0, bus.cyc_done}, {24'd0, vecs[k].exp_cd});
    end

    // extremes: duty 0, duty == period, period 0
    do_reset();
    set_ch(1, 10, 0); set_ch(2, 10, 10); set_ch(3, 0, 5);
    bus.en = 8'b0000_1110;
    tick();
    bad1 = 0; bad2 = 0; bad3 = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (bus.pwm[1]) bad1 = 1;
      if (!bus.pwm[2]) bad2 = 1;
      if (bus.active[3]) bad3 = 1;
    end
    check("duty0 pwm1 low", {31'd0, bad1}, 32'd0);
    check("full duty pwm2 high", {31'd0, bad2}, 32'd0);
    check("period0 active3", {31'd0, bad3}, 32'd0);
    check("extremes active", {30'd0, bus.active[2:1]}, 32'd3);

    // shadowing: duty rewritten mid-period takes effect next period
    do_reset();
    set_ch(0, 10, 3); bus.en = 8'h01;
    tick();
    h1 = 0; h2 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.pwm[0]) begin
        if (k <= 10) h1++; else h2++;
      end
      if (k == 4) set_ch(0, 10, 7);
    end
    check("shadow first period highs", h1, 3);
    check("shadow second period highs", h2, 7);

    // disable mid-period: period completes with one pulse, then idle
    do_reset();
    set_ch(0, 10, 3); bus.en = 8'h01;
    tick(); tick(); tick();
    bus.en = 8'h00;
    ncd = 0;
    for (int k = 3; k <= 15; k++) begin
      tick();
      if (bus.cyc_done[0]) ncd++;
      if (k == 10) check("disable pulse at wrap", {31'd0, bus.cyc_done[0]}, 32'd1);
    end
    check("disable single pulse", ncd, 1);
    check("disable idle active", {31'd0, bus.active[0]}, 32'd0);
    check("disable idle pwm", {31'd0, bus.pwm[0]}, 32'd0);

    // restart aligns two channels; restart on a wrap edge suppresses cyc_done
    do_reset();
    set_ch(0, 8, 4); set_ch(1, 12, 4); bus.en = 8'h03;
    tick();
    for (int k = 1; k <= 5; k++) tick();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check("restart no pulse", {30'd0, bus.cyc_done[1:0]}, 32'd0);
    misalign = 0;
    for (int k = 7; k <= 13; k++) begin
      tick();
      if (bus.pwm[0] !== bus.pwm[1]) misalign = 1;
      if (k == 7) check("restart first high", {30'd0, bus.pwm[1:0]}, 32'd3);
      if (k == 11) check("restart first low", {30'd0, bus.pwm[1:0]}, 32'd0);
    end
    check("restart aligned", {31'd0, misalign}, 32'd0);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check("restart on wrap no cyc_done", {31'd0, bus.cyc_done[0]}, 32'd0);
    tick();
    check("restart on wrap realign", {30'd0, bus.pwm[1:0]}, 32'd3);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 19) == 0) bus.en[c] = ~bus.en[c];
        if ($urandom_range(0, 14) == 0) set_ch(c, $urandom_range(0, 12), $urandom_range(0, 14));
      end
      bus.restart = ($urandom_range(0, 39) == 0);
      tick();
      check("rand pwm", {24'd0, bus.pwm}, {24'd0, m_pwm});
      check("rand active", {24'd0, bus.active}, {24'd0, m_act});
      check("rand cyc_done", {24'd0, bus.cyc_done}, {24'd0, m_cd});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
